window_gen_3x3: RTL
===================

Name: window_gen_3x3

Overview:
Sliding-window generator directly upstream of the 3x3 convolution core.
- Consumes a raster-order stream of FP16 activation pixels from the DMA core.
- Buffers two image rows on chip.
- Emits one complete 3x3 window per valid output position, stride 1, no padding, so the conv core receives all nine operands in parallel.
- Frame geometry is set per layer by the control bus.

Parameters:
DW, 16, pixel width in bits (FP16)
MAX_W, 256, maximum supported image width, sets line-buffer depth
CW, 9, width of geometry counters and inputs, must satisfy 2^CW > MAX_W

Ports:
clk  input  1  core clock
rst  input  1  asynchronous active-high reset
start  input  1  one-cycle pulse; latches geometry and begins a frame
img_w  input  CW  image width in pixels, valid when start=1
img_h  input  CW  image height in pixels, valid when start=1
busy  output  1  high from accepted start until done
done  output  1  one-cycle pulse after the last window is accepted
err  output  1  one-cycle pulse when start is rejected for bad geometry
in_data  input  DW  incoming pixel
in_valid  input  1  in_data valid
in_ready  output  1  block accepts in_data this cycle
win_data  output  9*DW  window; slot k at bits [k*DW +: DW], row-major, k=0 top-left, k=8 bottom-right
win_valid  output  1  win_data valid
win_ready  input  1  conv core accepts window

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE; busy=0, done=0, err=0, in_ready=0, win_valid=0, win_data=0; all counters 0.
- Line buffers are not cleared on reset.

States:
- IDLE:
  - start with 3<=img_w<=MAX_W and 3<=img_h: latch geometry, clear col/row counters, go to RUN, assert busy next cycle.
  - start with any other geometry: pulse err, stay in IDLE.
- RUN:
  - in_ready = !win_valid || win_ready.
  - A pixel is accepted when in_valid && in_ready.
  - On each accepted pixel at (row r, col c):
    - line buffers shift: lb1[c] <= lb0[c], lb0[c] <= in_data.
    - 3x3 shift-register columns shift left, loading new column {lb1[c], lb0[c], in_data} (top to bottom).
    - c increments; at img_w-1, c wraps to 0 and r increments.
  - Window output:
    - An accepted pixel with r>=2 && c>=2 loads win_data with the updated shift register and sets win_valid the next cycle.
    - Latency from pixel acceptance to win_valid is 1 cycle.
  - Window handshake:
    - win_valid stays high, with win_data stable, until win_ready.
    - Accept and reload in the same cycle is allowed, giving full throughput of 1 window per cycle.
  - After the pixel at (img_h-1, img_w-1) is accepted, in_ready=0 and the state goes to DRAIN.
- DRAIN: when the final window is accepted, pulse done, drop busy, go to IDLE.
- start outside IDLE is ignored. Geometry is not re-latched and err is not raised.
- Totals: windows per frame = (img_w-2)*(img_h-2); pixels per frame = img_w*img_h.
- Windows never straddle a row boundary. Columns 0 and 1 of each row only prime the shift register.
- rst mid-frame aborts immediately to reset values. The next frame needs a new start.
- No arithmetic is applied to pixel values; data passes through bit-exact.

Optional Feature:
Macro: WIN_STRIDE2_EN
- Defined:
  - Adds input port stride2 (1 bit), latched at start.
  - When stride2=1, a window is emitted only when (r-2) and (c-2) are both even.
  - Windows per frame become floor((img_w-3)/2+1)*floor((img_h-3)/2+1).
  - All pixels are still consumed.
- Undefined: port absent, stride fixed at 1, behaviour exactly as above.

Test Plan:
- 4x4 frame, pixels 0..15, win_ready=1 -> exactly 4 windows:
  - first {0,1,2,4,5,6,8,9,10}
  - last {5,6,7,9,10,11,13,14,15}
  - done 1 cycle after the 4th window is accepted.
- Same frame with win_ready held 0 for 5 cycles at the first window -> win_data stable, in_ready=0 while win_valid, no window lost or duplicated.
- start with img_w=2 (also img_w=MAX_W+1) -> err pulse, busy stays 0, in_ready=0.
- 8x5 frame with in_valid toggling randomly -> 18 windows matching the golden model; the second start pulse mid-frame is ignored.
- Assert rst after 10 pixels of a 6x6 frame -> all outputs 0 the same cycle; a new start with 3x3 geometry yields a single window of pixels 0..8.
- With WIN_STRIDE2_EN, 7x7 frame, stride2=1 -> 9 windows, top-left pixels at (0,0),(0,2),(0,4),(2,0)...(4,4).

Source files
------------

// File: rtl/window_gen_3x3.sv
// 3x3 sliding-window generator: two on-chip line buffers feed a 3x3
// shift register; emits one window per valid stride-1 output position.
// Optional build macro WIN_STRIDE2_EN adds a stride2 input latched at start.
module window_gen_3x3 #(
  parameter int DW    = 16,
  parameter int MAX_W = 256,
  parameter int CW    = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CW-1:0]   img_w,
  input  logic [CW-1:0]   img_h,
`ifdef WIN_STRIDE2_EN
  input  logic            stride2,
`endif
  output logic            busy,
  output logic            done,
  output logic            err,
  input  logic [DW-1:0]   in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [9*DW-1:0] win_data,
  output logic            win_valid,
  input  logic            win_ready
);

  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] w_q, w_d;
  logic [CW-1:0] h_q, h_d;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;

  logic [8:0][DW-1:0] sr_q, sr_d, sr_nx;

  logic [9*DW-1:0] win_q, win_d;
  logic            wv_q, wv_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

`ifdef WIN_STRIDE2_EN
  logic            s2_q, s2_d;
`endif

  logic [DW-1:0] lb0 [MAX_W];
  logic [DW-1:0] lb1 [MAX_W];

  logic [AW-1:0] ci;
  logic [DW-1:0] lb0_rd;
  logic [DW-1:0] lb1_rd;

  logic geom_ok;
  logic accept;
  logic last_col;
  logic last_pix;
  logic emit;

  assign ci     = col_q[AW-1:0];
  assign lb0_rd = lb0[ci];
  assign lb1_rd = lb1[ci];

  assign geom_ok = (img_w >= CW'(3)) &&
                   (img_w <= CW'(MAX_W)) &&
                   (img_h >= CW'(3));

  assign in_ready = (state_q == RUN) && (!wv_q || win_ready);
  assign accept   = in_valid && in_ready;
  assign last_col = (col_q == w_q - CW'(1));
  assign last_pix = last_col && (row_q == h_q - CW'(1));

`ifdef WIN_STRIDE2_EN
  assign emit = (row_q >= CW'(2)) && (col_q >= CW'(2)) &&
                (!s2_q || (!row_q[0] && !col_q[0]));
`else
  assign emit = (row_q >= CW'(2)) && (col_q >= CW'(2));
`endif

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign win_data  = win_q;
  assign win_valid = wv_q;

  // Shift register after the incoming column {lb1, lb0, pixel} is loaded.
  always_comb begin
    sr_nx    = sr_q;
    sr_nx[0] = sr_q[1];
    sr_nx[1] = sr_q[2];
    sr_nx[2] = lb1_rd;
    sr_nx[3] = sr_q[4];
    sr_nx[4] = sr_q[5];
    sr_nx[5] = lb0_rd;
    sr_nx[6] = sr_q[7];
    sr_nx[7] = sr_q[8];
    sr_nx[8] = in_data;
  end

  // Frame FSM, raster counters and window output handshake.
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    col_d   = col_q;
    row_d   = row_q;
    sr_d    = sr_q;
    win_d   = win_q;
    wv_d    = wv_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
`ifdef WIN_STRIDE2_EN
    s2_d    = s2_q;
`endif
    if (wv_q && win_ready) begin
      wv_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (geom_ok) begin
            w_d     = img_w;
            h_d     = img_h;
            col_d   = '0;
            row_d   = '0;
`ifdef WIN_STRIDE2_EN
            s2_d    = stride2;
`endif
            state_d = RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (accept) begin
          sr_d = sr_nx;
          if (emit) begin
            win_d = sr_nx;
            wv_d  = 1'b1;
          end
          if (last_col) begin
            col_d = '0;
            row_d = row_q + CW'(1);
          end else begin
            col_d = col_q + CW'(1);
          end
          if (last_pix) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!wv_q || win_ready) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      sr_q    <= '0;
      win_q   <= '0;
      wv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef WIN_STRIDE2_EN
      s2_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      col_q   <= col_d;
      row_q   <= row_d;
      sr_q    <= sr_d;
      win_q   <= win_d;
      wv_q    <= wv_d;
      done_q  <= done_d;
      err_q   <= err_d;
`ifdef WIN_STRIDE2_EN
      s2_q    <= s2_d;
`endif
    end
  end

  // Line buffers: previous two rows, not cleared by reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[ci] <= lb0_rd;
      lb0[ci] <= in_data;
    end
  end

endmodule
